// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM/WB pipeline register with 2-entry skid buffer, flush,
// sub-word load extraction and an EX-stage forwarding tap.
module mem_wb_pipe #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        wb_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [REG_AW-1:0] ins_i,
    input  logic [2:0]        ld_type_i,
    input  logic              flush_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              mem_2_reg,
    output logic              reg_write,
    output logic [DATA_W-1:0] data_o,
    output logic [DATA_W-1:0] addr_o,
    output logic [REG_AW-1:0] ins_o,
    output logic [DATA_W-1:0] wb_value_o,
    output logic              fwd_en_o,
    output logic [REG_AW-1:0] fwd_rd_o,
    output logic [DATA_W-1:0] fwd_val_o
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    logic [OFF_W-1:0]  off;
    logic [7:0]        ld_b;
    logic [15:0]       ld_h;
    logic [DATA_W-1:0] ext;

    logic              m_valid, s_valid, rdy;
    logic [1:0]        m_wb, s_wb;
    logic [DATA_W-1:0] m_data, s_data, m_addr, s_addr;
    logic [REG_AW-1:0] m_ins, s_ins;

    logic accept, drain, ld_main_skid, ld_main_in, ld_skid_in, m_valid_n, s_valid_n;

    // Half-word selection ignores the low offset bit: no misalignment trap.
    always_comb begin
        off  = addr_i[OFF_W-1:0];
        ld_b = data_i[{off, 3'b000} +: 8];
        ld_h = data_i[{off[OFF_W-1:1], 4'b0000} +: 16];
        ext  = (ld_type_i == 3'b000) ? {{(DATA_W-8){ld_b[7]}}, ld_b} :
               (ld_type_i == 3'b100) ? {{(DATA_W-8){1'b0}}, ld_b} :
               (ld_type_i == 3'b001) ? {{(DATA_W-16){ld_h[15]}}, ld_h} :
               (ld_type_i == 3'b101) ? {{(DATA_W-16){1'b0}}, ld_h} : data_i;
    end

    // Flush overrides both moves; skid refills main whenever main retires.
    always_comb begin
        accept       = in_valid & rdy;
        drain        = m_valid & out_ready;
        ld_main_skid = !flush_i & drain & s_valid;
        ld_main_in   = !flush_i & accept & (!m_valid | drain) & !s_valid;
        ld_skid_in   = !flush_i & accept & !ld_main_in;
        m_valid_n    = flush_i ? 1'b0 : (ld_main_skid | ld_main_in) ? 1'b1 : drain ? 1'b0 : m_valid;
        s_valid_n    = flush_i ? 1'b0 : ld_skid_in ? 1'b1 : ld_main_skid ? 1'b0 : s_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            rdy     <= 1'b1;
            m_wb    <= '0;
            m_data  <= '0;
            m_addr  <= '0;
            m_ins   <= '0;
            s_wb    <= '0;
            s_data  <= '0;
            s_addr  <= '0;
            s_ins   <= '0;
        end else begin
            m_valid <= m_valid_n;
            s_valid <= s_valid_n;
            rdy     <= !s_valid_n;
            if (ld_main_skid) begin
                m_wb   <= s_wb;
                m_data <= s_data;
                m_addr <= s_addr;
                m_ins  <= s_ins;
            end else if (ld_main_in) begin
                m_wb   <= wb_i;
                m_data <= ext;
                m_addr <= addr_i;
                m_ins  <= ins_i;
            end
            if (ld_skid_in) begin
                s_wb   <= wb_i;
                s_data <= ext;
                s_addr <= addr_i;
                s_ins  <= ins_i;
            end
        end
    end

    always_comb begin
        in_ready   = rdy;
        out_valid  = m_valid;
        mem_2_reg  = m_wb[1];
        reg_write  = m_valid & m_wb[0] & ((ZERO_REG == 0) | (m_ins != '0));
        data_o     = m_data;
        addr_o     = m_addr;
        ins_o      = m_ins;
        wb_value_o = m_wb[1] ? m_data : m_addr;
        fwd_en_o   = reg_write;
        fwd_rd_o   = m_ins;
        fwd_val_o  = wb_value_o;
    end
endmodule
